rnn_matvec_ctrl: RTL and testbench
==================================

// Module: rnn_matvec_ctrl
// PURPOSE
//  Sequencer for the RNN parameter tensors: computes y = W*x for one cell step.
//  - Streams weight words into the W matrix store and input words into the x vector store.
//  - Sweeps both stores row by row, driving a single MAC.
//  - Emits each saturated Q8.8 result y[i] on a valid/ready output.
//  Sits between the host/DMA parameter stream and the activation stage.
// PARAMETERS
//  ROWS    2   W rows = number of outputs
//  COLS    4   W columns = x length
//  DW      16  data width, signed Q(DW-FRAC).FRAC
//  FRAC    8   fractional bits
//  ACC_W   40  accumulator width (>= 2*DW + clog2(COLS))
//  SELI_W  2   W row-select width
//  SELJ_W  4   column/vector select width
// PORTS
//  clk         in   1       clock
//  reset       in   1       synchronous, active-high reset
//  start       in   1       begin a step; sampled only in IDLE
//  load_x_only in   1       with start: skip the W load, reuse stored weights
//  busy        out  1       high in any non-IDLE state
//  done        out  1       1-cycle pulse after the last y handshake
//  in_valid    in   1       parameter word valid
//  in_ready    out  1       high in LOAD_W / LOAD_X
//  in_data     in   DW      parameter word
//  w_write     out  1       W store write strobe
//  w_seli      out  SELI_W  W row select
//  w_selj      out  SELJ_W  W column select
//  w_din       out  DW      W write data (= in_data)
//  w_dout      in   DW      W read data, combinational from w_seli/w_selj
//  x_write     out  1       x store write strobe
//  x_sel       out  SELJ_W  x select
//  x_din       out  DW      x write data (= in_data)
//  x_dout      in   DW      x read data, combinational from x_sel
//  y_valid     out  1       result valid
//  y_ready     in   1       result accepted
//  y_data      out  DW      saturated y[i]
//  y_idx       out  SELI_W  row index i of y_data
// BEHAVIOUR
//  - Clock/reset: one clock; reset is synchronous and active-high.
//  - Reset values: state=IDLE; counters i,j=0; acc=0; all outputs 0.
//  - Tensor store contents are not cleared by this block.
//  - FSM:
//    - IDLE -start&!load_x_only-> LOAD_W.
//    - IDLE -start&load_x_only-> LOAD_X.
//    - LOAD_W: ROWS*COLS handshakes, row-major (j fastest), then LOAD_X.
//    - LOAD_X: COLS handshakes, then MAC.
//    - MAC: COLS cycles per row, then OUT.
//    - OUT: on y_ready, go MAC (next row) or IDLE (last row).
//  - Load handshake:
//    - A word transfers when in_valid & in_ready.
//    - w_write/x_write = in_valid & in_ready & (state match), same cycle, combinational.
//    - Selects come from registered counters i,j; counters advance only on transfer.
//    - in_valid gaps stall the load without side effects.
//  - MAC:
//    - w_seli=i, w_selj=j, x_sel=j; one product per cycle.
//    - Product is signed DW*DW -> 2*DW, sign-extended into acc.
//    - First cycle of a row: acc = product (no stale add). Later cycles: acc += product.
//  - OUT:
//    - y_data = sat_DW(acc >>> FRAC), registered on entry to OUT.
//    - Saturation bounds: max 0x7FFF, min 0x8000 for DW=16.
//    - y_valid, y_data, y_idx held stable until y_ready; no MAC activity while stalled.
//  - Latency:
//    - Per row: COLS MAC cycles + >=1 OUT cycle.
//    - done pulses the cycle after the final OUT handshake (state back in IDLE).
//  - Boundaries:
//    - start while busy: ignored.
//    - in_valid outside LOAD states: ignored (in_ready=0, no writes).
//    - Counter wrap: j wraps COLS-1 -> 0 while i increments. No select value >= ROWS/COLS is ever driven.
//    - reset mid-operation: immediate return to IDLE, no done pulse, partial loads discarded (store keeps written words).
//    - y_ready asserted with y_valid low: no effect.
// STRUCTURE
//  - Package rnn_pkg: state enum {IDLE, LOAD_W, LOAD_X, MAC, OUT}; DW/FRAC defaults; sat_q function.
//  - Sub-module rnn_mac_sat: accumulate, shift and saturate datapath.
//  - This file holds the FSM, counters and handshake logic.
// TESTING (ROWS=2, COLS=4, Q8.8)
//  1. Basic step:
//     - Stimulus: start; W all 0x0100; x=[0x0100,0x0200,0x0300,0x0400].
//     - Response: y0=y1=0x0A00 (idx 0, then 1); done pulse; 12 write strobes total.
//  2. Saturation:
//     - Stimulus: W all 0x7FFF, x all 0x7FFF.
//     - Response: y=0x7FFF.
//     - Stimulus: W all 0x8000, x all 0x7FFF.
//     - Response: y=0x8000.
//  3. Output backpressure:
//     - Stimulus: y_ready low 5 cycles on row 0.
//     - Response: y_valid stays high; y_data/y_idx stable; row 1 MAC starts only after the handshake.
//  4. Weight reuse:
//     - Stimulus: after test 1, start with load_x_only=1; x all 0x0200.
//     - Response: no w_write; y0=y1=0x0800.
//  5. Input gaps and ignored start:
//     - Stimulus: in_valid toggled every other cycle during load; start pulsed mid-load.
//     - Response: exactly 12 writes at correct selects; the extra start has no effect.
//  6. Reset mid-MAC:
//     - Stimulus: assert reset during row 1.
//     - Response: next cycle busy=0, y_valid=0, done=0; a fresh start completes normally.

Source files
------------

// File: rtl/rnn_pkg.sv
// rtl/rnn_pkg.sv - shared state encoding, default widths and the Q-format saturation helper
package rnn_pkg;

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, MAC, OUT} state_e;

    localparam int DW_DEF   = 16;
    localparam int FRAC_DEF = 8;

    // Clamp a sign-extended value to the signed range of a dw-bit word.
    function automatic logic signed [63:0] sat_q(input logic signed [63:0] v,
                                                 input int unsigned dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/rnn_mac_sat.sv
// rtl/rnn_mac_sat.sv - single MAC with row accumulator, Q-format shift and saturating result register
module rnn_mac_sat
    import rnn_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int ACC_W = 40
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mac_en_i,
    input  logic          first_i,
    input  logic          capture_i,
    input  logic [DW-1:0] w_i,
    input  logic [DW-1:0] x_i,
    output logic [DW-1:0] y_o
);

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] shifted;
    logic signed [63:0]      shifted_ext;
    logic        [DW-1:0]    y_q, y_d;

    assign prod     = $signed(w_i) * $signed(x_i);
    assign prod_ext = {{(ACC_W - 2*DW){prod[2*DW-1]}}, prod};

    // The first product of a row overwrites the accumulator so no stale row leaks in.
    always_comb begin
        acc_d = acc_q;
        if (mac_en_i) begin
            acc_d = first_i ? prod_ext : acc_q + prod_ext;
        end
    end

    // Capture uses acc_d so the final product of the row is included.
    assign shifted     = acc_d >>> FRAC;
    assign shifted_ext = {{(64 - ACC_W){shifted[ACC_W-1]}}, shifted};

    always_comb begin
        y_d = y_q;
        if (capture_i) begin
            y_d = DW'(sat_q(shifted_ext, DW));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            y_q   <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/rnn_matvec_ctrl.sv
// rtl/rnn_matvec_ctrl.sv - load/MAC/output sequencer computing y = W*x for one RNN cell step
module rnn_matvec_ctrl
    import rnn_pkg::*;
#(
    parameter int ROWS   = 2,
    parameter int COLS   = 4,
    parameter int DW     = DW_DEF,
    parameter int FRAC   = FRAC_DEF,
    parameter int ACC_W  = 40,
    parameter int SELI_W = 2,
    parameter int SELJ_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_x_only,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    output logic              w_write,
    output logic [SELI_W-1:0] w_seli,
    output logic [SELJ_W-1:0] w_selj,
    output logic [DW-1:0]     w_din,
    input  logic [DW-1:0]     w_dout,
    output logic              x_write,
    output logic [SELJ_W-1:0] x_sel,
    output logic [DW-1:0]     x_din,
    input  logic [DW-1:0]     x_dout,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [DW-1:0]     y_data,
    output logic [SELI_W-1:0] y_idx
);

    localparam logic [SELI_W-1:0] I_LAST = SELI_W'(ROWS - 1);
    localparam logic [SELJ_W-1:0] J_LAST = SELJ_W'(COLS - 1);

    state_e            state_q, state_d;
    logic [SELI_W-1:0] i_q, i_d;
    logic [SELJ_W-1:0] j_q, j_d;
    logic              done_q, done_d;
    logic              xfer;
    logic              mac_en;

    assign in_ready = (state_q == LOAD_W) || (state_q == LOAD_X);
    assign xfer     = in_valid && in_ready;
    assign mac_en   = (state_q == MAC);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = load_x_only ? LOAD_X : LOAD_W;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            LOAD_W: begin
                if (xfer) begin
                    if (j_q == J_LAST) begin
                        j_d = '0;
                        if (i_q == I_LAST) begin
                            i_d     = '0;
                            state_d = LOAD_X;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            LOAD_X: begin
                if (xfer) begin
                    if (j_q == J_LAST) begin
                        j_d     = '0;
                        i_d     = '0;
                        state_d = MAC;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            MAC: begin
                if (j_q == J_LAST) begin
                    j_d     = '0;
                    state_d = OUT;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            OUT: begin
                if (y_ready) begin
                    if (i_q == I_LAST) begin
                        i_d     = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = MAC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            done_q  <= done_d;
        end
    end

    rnn_mac_sat #(
        .DW   (DW),
        .FRAC (FRAC),
        .ACC_W(ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .mac_en_i (mac_en),
        .first_i  (j_q == '0),
        .capture_i(mac_en && (j_q == J_LAST)),
        .w_i      (w_dout),
        .x_i      (x_dout),
        .y_o      (y_data)
    );

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign w_write = xfer && (state_q == LOAD_W);
    assign x_write = xfer && (state_q == LOAD_X);
    assign w_seli  = i_q;
    assign w_selj  = j_q;
    assign x_sel   = j_q;
    assign w_din   = in_data;
    assign x_din   = in_data;
    assign y_valid = (state_q == OUT);
    assign y_idx   = i_q;

endmodule

// File: tb/tb_rnn_matvec_ctrl.sv
// tb/tb_rnn_matvec_ctrl.sv - directed self-checking bench with a behavioural matrix-vector model
module tb_rnn_matvec_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        load_x_only = 1'b0;
    logic        busy, done;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        w_write;
    logic [1:0]  w_seli;
    logic [3:0]  w_selj;
    logic [15:0] w_din, w_dout;
    logic        x_write;
    logic [3:0]  x_sel;
    logic [15:0] x_din, x_dout;
    logic        y_valid;
    logic        y_ready = 1'b1;
    logic [15:0] y_data;
    logic [1:0]  y_idx;

    rnn_matvec_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .load_x_only(load_x_only),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .w_write(w_write), .w_seli(w_seli), .w_selj(w_selj),
        .w_din(w_din), .w_dout(w_dout), .x_write(x_write), .x_sel(x_sel),
        .x_din(x_din), .x_dout(x_dout), .y_valid(y_valid), .y_ready(y_ready),
        .y_data(y_data), .y_idx(y_idx)
    );

    always #5 clk = ~clk;

    logic [15:0] wmem [2][4];
    logic [15:0] xmem [4];
    always @(posedge clk) begin
        if (w_write && w_seli < 2 && w_selj < 4) wmem[w_seli][w_selj] <= w_din;
        if (x_write && x_sel < 4) xmem[x_sel] <= x_din;
    end
    assign w_dout = (w_seli < 2 && w_selj < 4) ? wmem[w_seli][w_selj] : 16'h0;
    assign x_dout = (x_sel < 4) ? xmem[x_sel] : 16'h0;

    int checks = 0;
    int errors = 0;
    int wcnt = 0, xcnt = 0, done_cnt = 0;
    logic [15:0] cur_w [2][4];
    logic [15:0] cur_x [4];
    logic [15:0] got_y [2];
    int          exp_idx [$];
    logic [15:0] exp_dat [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] model_y(input int r);
        longint s = 0;
        for (int c = 0; c < 4; c++)
            s += longint'($signed(cur_w[r][c])) * longint'($signed(cur_x[c]));
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            check("sel_range", {29'd0, (w_seli < 2), (w_selj < 4), (x_sel < 4)}, 32'h7);
            if (y_valid && y_ready) begin
                if (exp_dat.size() == 0) begin
                    check("y_unexpected", 32'd1, 32'd0);
                end else begin
                    check("y_idx", 32'(y_idx), 32'(exp_idx[0]));
                    check("y_data", 32'(y_data), 32'(exp_dat[0]));
                    got_y[y_idx[0]] = y_data;
                    void'(exp_idx.pop_front());
                    void'(exp_dat.pop_front());
                end
            end
            if (w_write) begin
                check("w_seli", 32'(w_seli), 32'(wcnt / 4));
                check("w_selj", 32'(w_selj), 32'(wcnt % 4));
                wcnt++;
            end
            if (x_write) begin
                check("x_sel", 32'(x_sel), 32'(xcnt % 4));
                xcnt++;
            end
            if (done) begin
                done_cnt++;
                check("done_idle_all_y", {30'd0, busy, exp_dat.size() != 0}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'd1, 32'd0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_step(input bit xonly, input bit gaps, input bit extra_start, input bit wait_done);
        int d0, n;
        for (int r = 0; r < 2; r++) begin
            exp_idx.push_back(r);
            exp_dat.push_back(model_y(r));
        end
        wcnt = 0;
        xcnt = 0;
        start = 1'b1;
        load_x_only = xonly;
        tick();
        start = 1'b0;
        load_x_only = 1'b0;
        if (!xonly) begin
            for (int k = 0; k < 8; k++) begin
                if (extra_start && k == 3) start = 1'b1;
                send_word(cur_w[k / 4][k % 4]);
                start = 1'b0;
                if (gaps) tick();
            end
        end
        for (int k = 0; k < 4; k++) begin
            send_word(cur_x[k]);
            if (gaps) tick();
        end
        if (wait_done) begin
            d0 = done_cnt;
            n = 0;
            while (done_cnt == d0 && n < 300) begin
                tick();
                n++;
            end
            if (n >= 300) check("done_timeout", 32'd1, 32'd0);
            check("y_all_seen", 32'(exp_dat.size()), 32'd0);
            check("w_writes", 32'(wcnt), xonly ? 32'd0 : 32'd8);
            check("x_writes", 32'(xcnt), 32'd4);
            check("total_writes", 32'(wcnt + xcnt), xonly ? 32'd4 : 32'd12);
        end
    endtask

    task automatic set_all(input logic [15:0] wv, input logic [15:0] xv);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) cur_w[r][c] = wv;
        for (int c = 0; c < 4; c++) cur_x[c] = xv;
    endtask

    initial begin
        int n, gap, d0;
        logic [15:0] hold_d;

        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outs", {26'd0, y_valid, done, in_ready, w_write, x_write, 1'b0}, 32'd0);
        check("rst_y", {14'd0, y_idx, y_data}, 32'd0);
        reset = 1'b0;
        tick();

        in_valid = 1'b1;
        in_data = 16'h1234;
        repeat (2) begin
            @(negedge clk);
            check("idle_ignore_in", {29'd0, in_ready, w_write, x_write}, 32'd0);
        end
        tick();
        in_valid = 1'b0;

        // Test 1: basic step
        set_all(16'h0100, 16'h0);
        cur_x[0] = 16'h0100; cur_x[1] = 16'h0200; cur_x[2] = 16'h0300; cur_x[3] = 16'h0400;
        check("model_pin_basic", 32'(model_y(0)), 32'h0A00);
        run_step(0, 0, 0, 1);
        check("t1_y0", 32'(got_y[0]), 32'h0A00);
        check("t1_y1", 32'(got_y[1]), 32'h0A00);

        // Test 4: weight reuse
        for (int c = 0; c < 4; c++) cur_x[c] = 16'h0200;
        run_step(1, 0, 0, 1);
        check("t4_y0", 32'(got_y[0]), 32'h0800);
        check("t4_y1", 32'(got_y[1]), 32'h0800);

        // Test 2: saturation both ways
        set_all(16'h7FFF, 16'h7FFF);
        run_step(0, 0, 0, 1);
        check("t2_ymax", 32'(got_y[1]), 32'h7FFF);
        set_all(16'h8000, 16'h7FFF);
        run_step(0, 0, 0, 1);
        check("t2_ymin", 32'(got_y[0]), 32'h8000);

        // Test 3: output backpressure on row 0
        cur_w[0][0] = 16'h0100; cur_w[0][1] = 16'hFF00; cur_w[0][2] = 16'h0200; cur_w[0][3] = 16'h0080;
        for (int c = 0; c < 4; c++) begin
            cur_w[1][c] = 16'h0080;
            cur_x[c] = 16'h0100;
        end
        check("model_pin_bp", 32'(model_y(0)), 32'h0280);
        fork
            run_step(0, 0, 0, 1);
            begin
                y_ready = 1'b0;
                n = 0;
                while (!y_valid && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 200) check("bp_wait_timeout", 32'd1, 32'd0);
                hold_d = y_data;
                check("bp_first_y", 32'(hold_d), 32'h0280);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_valid_held", 32'(y_valid), 32'd1);
                    check("bp_data_held", 32'(y_data), 32'(hold_d));
                    check("bp_idx_held", 32'(y_idx), 32'd0);
                end
                tick();
                y_ready = 1'b1;
                tick();
                gap = 0;
                while (!y_valid && gap < 50) begin
                    @(negedge clk);
                    if (!y_valid) gap++;
                end
                check("bp_row1_gap", 32'(gap), 32'd4);
            end
        join
        check("t3_y1", 32'(got_y[1]), 32'h0200);

        // Test 5: input gaps with an ignored start mid-load
        for (int c = 0; c < 4; c++) cur_w[0][c] = 16'(16'h0100 * (c + 1));
        cur_w[1][0] = 16'hFF00; cur_w[1][1] = 16'h0100; cur_w[1][2] = 16'hFF00; cur_w[1][3] = 16'h0100;
        cur_x[0] = 16'h0100; cur_x[1] = 16'h0080; cur_x[2] = 16'h0040; cur_x[3] = 16'h0020;
        run_step(0, 1, 1, 1);
        check("t5_y0", 32'(got_y[0]), 32'h0340);
        check("t5_y1", 32'(got_y[1]), 32'hFF60);
        repeat (3) tick();
        check("t5_idle_after", 32'(busy), 32'd0);

        // Test 6: reset during row 1 MAC
        set_all(16'h0100, 16'h0100);
        run_step(0, 0, 0, 0);
        n = 0;
        while (!y_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("t6_wait_timeout", 32'd1, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        d0 = done_cnt;
        tick();
        check("t6_rst_outs", {29'd0, busy, y_valid, done}, 32'd0);
        reset = 1'b0;
        exp_idx.delete();
        exp_dat.delete();
        repeat (10) begin
            @(negedge clk);
            check("t6_no_done", 32'(done), 32'd0);
        end
        check("t6_done_cnt", 32'(done_cnt), 32'(d0));
        tick();
        for (int c = 0; c < 4; c++) cur_x[c] = 16'h0300;
        run_step(0, 0, 0, 1);
        check("t6_fresh_y0", 32'(got_y[0]), 32'h0C00);
        check("t6_fresh_y1", 32'(got_y[1]), 32'h0C00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
